// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_scheduler
// Brief    : Round-robin ALU/load writeback arbiter driving the register file
//            write port, plus a per-register busy scoreboard for RAW/WAW stalls.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int NUM_REGS     = 32,
  parameter bit ZERO_PROTECT = 1'b1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              ResvValid,
  input  logic [ADDR_W-1:0] ResvReg,
  output logic              ResvReady,
  input  logic              AluValid,
  input  logic [ADDR_W-1:0] AluReg,
  input  logic [DATA_W-1:0] AluData,
  output logic              AluReady,
  input  logic              MemValid,
  input  logic [ADDR_W-1:0] MemReg,
  input  logic [DATA_W-1:0] MemData,
  output logic              MemReady,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic              Busy1,
  output logic              Busy2,
  output logic [ADDR_W:0]   PendingCount,
  output logic              ErrUnresv
);

  localparam logic [NUM_REGS-1:0] c_oneHot0 = {{(NUM_REGS-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]   c_zeroReg = '0;

  logic                r_favorMem;
  logic [NUM_REGS-1:0] r_busy;
  logic                r_regWrite;
  logic [ADDR_W-1:0]   r_writeReg;
  logic [DATA_W-1:0]   r_writeData;
  logic                r_errUnresv;

  logic                w_aluGrant;
  logic                w_memGrant;
  logic                w_wbFire;
  logic                w_wbLoad;
  logic [ADDR_W-1:0]   w_wbReg;
  logic [DATA_W-1:0]   w_wbData;
  logic                w_resvAccept;
  logic                w_resvSets;
  logic [NUM_REGS-1:0] w_setMask;
  logic [NUM_REGS-1:0] w_clrMask;
  logic [NUM_REGS-1:0] w_busyNext;
  logic                w_errHit;
  logic [ADDR_W:0]     w_pending;

  // Grants are gated by Rst_n so no handshake can complete while in reset.
  always_comb begin
    w_aluGrant = 1'b0;
    w_memGrant = 1'b0;
    if (Rst_n) begin
      if (AluValid && MemValid) begin
        w_aluGrant = ~r_favorMem;
        w_memGrant = r_favorMem;
      end else begin
        w_aluGrant = AluValid;
        w_memGrant = MemValid;
      end
    end
  end

  always_comb begin
    w_wbFire = w_aluGrant | w_memGrant;
    w_wbReg  = w_memGrant ? MemReg  : AluReg;
    w_wbData = w_memGrant ? MemData : AluData;
    w_wbLoad = w_wbFire && !(ZERO_PROTECT && (w_wbReg == c_zeroReg));
  end

  // A register whose clearing write commits this cycle is still busy here.
  always_comb begin
    w_resvAccept = Rst_n && ResvValid && !r_busy[ResvReg];
    w_resvSets   = w_resvAccept && !(ZERO_PROTECT && (ResvReg == c_zeroReg));
    w_setMask    = w_resvSets ? (c_oneHot0 << ResvReg) : '0;
    w_clrMask    = r_regWrite ? (c_oneHot0 << r_writeReg) : '0;
    w_busyNext   = (r_busy & ~w_clrMask) | w_setMask;
    w_errHit     = r_regWrite && !r_busy[r_writeReg] && (r_writeReg != c_zeroReg);
  end

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_pending = w_pending + {{ADDR_W{1'b0}}, r_busy[i]};
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_favorMem <= 1'b0;
    end else if (w_aluGrant) begin
      r_favorMem <= 1'b1;
    end else if (w_memGrant) begin
      r_favorMem <= 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_regWrite  <= 1'b0;
      r_writeReg  <= '0;
      r_writeData <= '0;
    end else begin
      r_regWrite <= w_wbLoad;
      if (w_wbFire) begin
        r_writeReg  <= w_wbReg;
        r_writeData <= w_wbData;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_busy      <= '0;
      r_errUnresv <= 1'b0;
    end else begin
      r_busy <= w_busyNext;
      if (w_errHit) begin
        r_errUnresv <= 1'b1;
      end
    end
  end

  assign AluReady     = w_aluGrant;
  assign MemReady     = w_memGrant;
  assign ResvReady    = w_resvAccept;
  assign RegWrite     = r_regWrite;
  assign WriteReg     = r_writeReg;
  assign WriteData    = r_writeData;
  assign Busy1        = r_busy[ReadReg1];
  assign Busy2        = r_busy[ReadReg2];
  assign PendingCount = w_pending;
  assign ErrUnresv    = r_errUnresv;

endmodule
`default_nettype wire
